// File: rtl/c_arb_pkg.sv
// ---------------------------------------------------------------------------
// c_arb_pkg
// Shared definitions for the arbiter family.
//   RESET_TYPE_*  : reset style identifiers (this family uses synchronous).
//   clog2()       : ceiling log2 for sizing index fields.
//   eff_weight()  : maps a zero weight to 1 so every port gets at least one
//                   grant per round.
// ---------------------------------------------------------------------------
package c_arb_pkg;

    localparam int RESET_TYPE_ASYNC = 0;
    localparam int RESET_TYPE_SYNC  = 1;
    localparam int RESET_TYPE       = RESET_TYPE_SYNC;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] eff_weight(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/c_wmatrix_prio_state.sv
// ---------------------------------------------------------------------------
// c_wmatrix_prio_state
// Pairwise priority matrix. Only the upper triangle (r<c) is stored; the
// lower triangle is the complement of its transpose and the diagonal is 1.
// o_state[r][c]=1 means port r beats port c.
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset (all ones,
//                        i.e. port 0 highest, last port lowest)
//   i_demote_en        : apply a demotion this edge
//   i_demote_onehot    : port to demote (bit i = port i); it loses to all
//   o_state            : full matrix [row][col], bit index = port number
// ---------------------------------------------------------------------------
module c_wmatrix_prio_state #(
    parameter int num_ports = 8
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_demote_en,
    input  logic [num_ports-1:0]                i_demote_onehot,
    output logic [num_ports-1:0][num_ports-1:0] o_state
);

    localparam int NUM_UP = num_ports * (num_ports - 1) / 2;

    logic [NUM_UP-1:0] r_up;

    // Flat index of upper-triangle element (r,c), r<c.
    function automatic int upi(input int r, input int c);
        return r * num_ports - (r * (r + 1)) / 2 + (c - r - 1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_up <= '1;
        end else if (i_demote_en) begin
            for (int r = 0; r < num_ports; r++) begin
                for (int c = r + 1; c < num_ports; c++) begin
                    if (i_demote_onehot[r])
                        r_up[upi(r, c)] <= 1'b0;
                    else if (i_demote_onehot[c])
                        r_up[upi(r, c)] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_state = '0;
        for (int r = 0; r < num_ports; r++) begin
            for (int c = 0; c < num_ports; c++) begin
                if (r == c)
                    o_state[r][c] = 1'b1;
                else if (r < c)
                    o_state[r][c] = r_up[upi(r, c)];
                else
                    o_state[r][c] = ~r_up[upi(c, r)];
            end
        end
    end

endmodule

// File: rtl/c_wmatrix_arbiter.sv
// ---------------------------------------------------------------------------
// c_wmatrix_arbiter
// Weighted matrix arbiter with strict priority classes. The winner keeps top
// priority for eff_weight(weight[g]) counted grants, then is demoted.
// Optional packet lock: define C_WMATRIX_ARB_LOCK_EN (adds i_tail).
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_active       : state-update enable
//   i_req_pr       : requests, class-major (class 0 in MSBs, port 0 MSB)
//   i_weight       : per-port quota, port 0 in MSBs
//   i_update       : commit current grant into arbiter state
//   i_tail         : transfer ends this cycle (lock build only)
//   o_gnt_pr       : one-hot grant within the selected class
//   o_gnt          : merged one-hot grant (port 0 MSB)
// ---------------------------------------------------------------------------
module c_wmatrix_arbiter
    import c_arb_pkg::*;
#(
    parameter int num_ports      = 8,
    parameter int weight_width   = 4,
    parameter int num_priorities = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_active,
    input  logic [num_priorities*num_ports-1:0]  i_req_pr,
    input  logic [num_ports*weight_width-1:0]    i_weight,
    input  logic                                 i_update,
`ifdef C_WMATRIX_ARB_LOCK_EN
    input  logic                                 i_tail,
`endif
    output logic [num_priorities*num_ports-1:0]  o_gnt_pr,
    output logic [num_ports-1:0]                 o_gnt
);

    // Internally bit i always means port i and index p means class p.
    logic [num_priorities-1:0][num_ports-1:0] w_req;
    logic [num_ports-1:0][weight_width-1:0]   w_wt;
    logic [num_ports-1:0]                     w_req_any;
    logic [num_ports-1:0][num_ports-1:0]      w_state;
    logic [num_priorities-1:0][num_ports-1:0] w_intm;
    logic [num_priorities-1:0]                w_cls_sel;
    logic                                     w_cls_found;
    logic [num_priorities-1:0][num_ports-1:0] w_mgnt_pr;
    logic [num_ports-1:0]                     w_mgnt;
    logic [num_priorities-1:0][num_ports-1:0] w_gnt_pr;
    logic [num_ports-1:0]                     w_gnt;
    logic                                     w_tail;
    logic                                     w_upd;
    logic [num_ports-1:0]                     w_hit;
    logic                                     w_demote_en;

    always_comb begin
        w_req     = '0;
        w_wt      = '0;
        w_req_any = '0;
        for (int p = 0; p < num_priorities; p++) begin
            for (int i = 0; i < num_ports; i++) begin
                w_req[p][i] = i_req_pr[(num_priorities-1-p)*num_ports + (num_ports-1-i)];
            end
            w_req_any = w_req_any | w_req[p];
        end
        for (int i = 0; i < num_ports; i++) begin
            w_wt[i] = i_weight[(num_ports-1-i)*weight_width +: weight_width];
        end
    end

    c_wmatrix_prio_state #(
        .num_ports (num_ports)
    ) u_state (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_demote_en     (w_demote_en),
        .i_demote_onehot (w_gnt),
        .o_state         (w_state)
    );

    // Port i wins class p if it beats (or is unopposed by) every other port.
    always_comb begin
        w_intm = '0;
        for (int p = 0; p < num_priorities; p++) begin
            for (int i = 0; i < num_ports; i++) begin
                w_intm[p][i] = w_req[p][i];
                for (int j = 0; j < num_ports; j++) begin
                    if (!(w_state[i][j] | ~w_req[p][j]))
                        w_intm[p][i] = 1'b0;
                end
            end
        end
    end

    // Highest non-empty class; the lowest class is the default.
    always_comb begin
        w_cls_sel   = '0;
        w_cls_found = 1'b0;
        for (int p = 0; p < num_priorities; p++) begin
            if (!w_cls_found && (|w_req[p])) begin
                w_cls_sel[p] = 1'b1;
                w_cls_found  = 1'b1;
            end
        end
        if (!w_cls_found)
            w_cls_sel[num_priorities-1] = 1'b1;
    end

    always_comb begin
        w_mgnt_pr = '0;
        w_mgnt    = '0;
        for (int p = 0; p < num_priorities; p++) begin
            if (w_cls_sel[p]) begin
                w_mgnt_pr[p] = w_intm[p];
                w_mgnt       = w_mgnt | w_intm[p];
            end
        end
    end

`ifdef C_WMATRIX_ARB_LOCK_EN
    logic [num_ports-1:0]                     r_lock;
    logic [num_ports-1:0]                     w_lock_hit;
    logic                                     w_locked;
    logic [num_priorities-1:0][num_ports-1:0] w_lock_pr;
    logic [num_ports-1:0]                     w_lock_taken;

    assign w_lock_hit = w_req_any & r_lock;
    assign w_locked   = |w_lock_hit;
    assign w_tail     = i_tail;

    // Locked port's grant lands in the highest class it is requesting in.
    always_comb begin
        w_lock_pr    = '0;
        w_lock_taken = '0;
        for (int p = 0; p < num_priorities; p++) begin
            for (int i = 0; i < num_ports; i++) begin
                if (!w_lock_taken[i] && w_lock_hit[i] && w_req[p][i]) begin
                    w_lock_pr[p][i] = 1'b1;
                    w_lock_taken[i] = 1'b1;
                end
            end
        end
    end

    assign w_gnt    = w_locked ? w_lock_hit : w_mgnt;
    assign w_gnt_pr = w_locked ? w_lock_pr  : w_mgnt_pr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lock <= '0;
        end else if (i_active) begin
            if (w_upd && !i_tail)
                r_lock <= w_gnt;
            else if (w_upd || !w_locked)
                r_lock <= '0;
        end
    end
`else
    assign w_tail   = 1'b1;
    assign w_gnt    = w_mgnt;
    assign w_gnt_pr = w_mgnt_pr;
`endif

    // A grant is committed only when something is actually granted.
    assign w_upd       = i_active & i_update & ~i_reset & (|w_gnt);
    assign w_demote_en = w_upd & w_tail & (|(w_hit & w_gnt));

    for (genvar i = 0; i < num_ports; i++) begin : g_cnt
        logic [weight_width-1:0] r_cnt;
        logic [weight_width:0]   w_inc;
        logic [31:0]             w_ew;

        assign w_inc    = {1'b0, r_cnt} + 1'b1;
        assign w_ew     = eff_weight({{(32-weight_width){1'b0}}, w_wt[i]});
        assign w_hit[i] = ({{(31-weight_width){1'b0}}, w_inc} >= w_ew);

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_cnt <= '0;
            end else if (w_upd) begin
                if (w_gnt[i]) begin
                    if (w_tail)
                        r_cnt <= w_hit[i] ? '0 : w_inc[weight_width-1:0];
                end else if (!w_req_any[i]) begin
                    r_cnt <= '0;
                end
            end
        end
    end

    always_comb begin
        o_gnt    = '0;
        o_gnt_pr = '0;
        for (int i = 0; i < num_ports; i++) begin
            o_gnt[num_ports-1-i] = ~i_reset & w_gnt[i];
            for (int p = 0; p < num_priorities; p++) begin
                o_gnt_pr[(num_priorities-1-p)*num_ports + (num_ports-1-i)] =
                    ~i_reset & w_gnt_pr[p][i];
            end
        end
    end

endmodule

// File: tb/tb_c_wmatrix_arbiter.sv
module tb_c_wmatrix_arbiter;

    typedef struct {
        string      tag;
        int         sel;      // 0: dut1 gnt, 1: dut2 gnt, 2: dut2 gnt_pr
        logic [7:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       active;
    logic       update;
    logic [11:0] weight;
    logic [3:0] req1;
    logic [7:0] req2;
    logic [3:0] gnt1;
    logic [3:0] gnt_pr1;
    logic [3:0] gnt2;
    logic [7:0] gnt_pr2;
`ifdef C_WMATRIX_ARB_LOCK_EN
    logic       tail;
`endif

    sb_t q_exp[$];
    int  n_checks = 0;
    int  n_errs   = 0;

    always #5 clk = ~clk;

    c_wmatrix_arbiter #(.num_ports(4), .weight_width(3), .num_priorities(1)) dut1 (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_active (active),
        .i_req_pr (req1),
        .i_weight (weight),
        .i_update (update),
`ifdef C_WMATRIX_ARB_LOCK_EN
        .i_tail   (tail),
`endif
        .o_gnt_pr (gnt_pr1),
        .o_gnt    (gnt1)
    );

    c_wmatrix_arbiter #(.num_ports(4), .weight_width(3), .num_priorities(2)) dut2 (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_active (active),
        .i_req_pr (req2),
        .i_weight (weight),
        .i_update (update),
`ifdef C_WMATRIX_ARB_LOCK_EN
        .i_tail   (tail),
`endif
        .o_gnt_pr (gnt_pr2),
        .o_gnt    (gnt2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop every expectation queued for this cycle.
    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            sb_t e;
            logic [7:0] obs;
            e = q_exp.pop_front();
            case (e.sel)
                0:       obs = {4'b0, gnt1};
                1:       obs = {4'b0, gnt2};
                default: obs = gnt_pr2;
            endcase
            check(e.tag, obs, e.exp);
        end
    end

    task automatic push(input string tag, input int sel, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        q_exp.push_back(e);
    endtask

    // One cycle on dut1: drive, queue expected grant, advance past the edge.
    task automatic step(input string tag, input logic [3:0] req, input logic upd,
                        input logic [3:0] exp_g);
        req1   = req;
        update = upd;
        push(tag, 0, {4'b0, exp_g});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        update = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        active = 1'b1;
        update = 1'b0;
        weight = '0;
        req1   = 4'b0000;
        req2   = 8'b0;
`ifdef C_WMATRIX_ARB_LOCK_EN
        tail   = 1'b1;
`endif
        // Grant is forced low while in reset.
        req1 = 4'b1111;
        push("rst_gnt", 0, 8'h00);
        @(posedge clk);
        #1;
        do_reset();

        // Equal weights: round robin in matrix order.
        weight = {3'd1, 3'd1, 3'd1, 3'd1};
        step("rr1", 4'b1111, 1'b1, 4'b1000);
        step("rr1", 4'b1111, 1'b1, 4'b0100);
        step("rr1", 4'b1111, 1'b1, 4'b0010);
        step("rr1", 4'b1111, 1'b1, 4'b0001);
        step("rr1", 4'b1111, 1'b1, 4'b1000);

        // Weight 0 behaves as weight 1.
        do_reset();
        weight = {3'd0, 3'd0, 3'd0, 3'd0};
        step("w0", 4'b1111, 1'b1, 4'b1000);
        step("w0", 4'b1111, 1'b1, 4'b0100);
        step("w0", 4'b1111, 1'b1, 4'b0010);

        // Weighted rounds {3,1,2,1}, two full rounds.
        do_reset();
        weight = {3'd3, 3'd1, 3'd2, 3'd1};
        for (int r = 0; r < 2; r++) begin
            repeat (3) step("w3121", 4'b1111, 1'b1, 4'b1000);
            step("w3121", 4'b1111, 1'b1, 4'b0100);
            repeat (2) step("w3121", 4'b1111, 1'b1, 4'b0010);
            step("w3121", 4'b1111, 1'b1, 4'b0001);
        end

        // Max weight: all-ones gives 2^3-1 consecutive grants.
        do_reset();
        weight = {3'd7, 3'd1, 3'd1, 3'd1};
        repeat (7) step("wmax", 4'b1111, 1'b1, 4'b1000);
        step("wmax", 4'b1111, 1'b1, 4'b0100);

        // Request drop clears cnt0 with no matrix change.
        do_reset();
        weight = {3'd3, 3'd1, 3'd2, 3'd1};
        step("drop", 4'b1111, 1'b1, 4'b1000);
        step("drop", 4'b0111, 1'b1, 4'b0100);
        repeat (3) step("drop", 4'b1111, 1'b1, 4'b1000);
        step("drop", 4'b1111, 1'b1, 4'b0010);

        // active low: state holds even with update.
        do_reset();
        weight = {3'd1, 3'd1, 3'd1, 3'd1};
        active = 1'b0;
        repeat (2) step("hold", 4'b1111, 1'b1, 4'b1000);
        active = 1'b1;
        step("hold", 4'b1111, 1'b1, 4'b1000);
        step("hold", 4'b1111, 1'b1, 4'b0100);

        // Update with no request has no effect.
        do_reset();
        step("noreq", 4'b0000, 1'b1, 4'b0000);
        step("noreq", 4'b1111, 1'b0, 4'b1000);

        // Mid-round reset: cnt2=1, port 2 on top.
        do_reset();
        weight = {3'd1, 3'd1, 3'd2, 3'd1};
        step("mid", 4'b1111, 1'b1, 4'b1000);
        step("mid", 4'b1111, 1'b1, 4'b0100);
        step("mid", 4'b1111, 1'b1, 4'b0010);
        reset = 1'b1;
        step("mid_rst", 4'b1111, 1'b1, 4'b0000);
        reset = 1'b0;
        step("mid_after", 4'b1111, 1'b0, 4'b1000);
        step("mid_after", 4'b1111, 1'b1, 4'b1000);
        step("mid_after", 4'b1111, 1'b1, 4'b0100);
        step("mid_after", 4'b1111, 1'b1, 4'b0010);
        step("mid_after", 4'b1111, 1'b1, 4'b0010);
        step("mid_after", 4'b1111, 1'b1, 4'b0001);

        // Two priority classes on dut2.
        do_reset();
        req1   = 4'b0000;
        update = 1'b0;
        req2   = {4'b0010, 4'b1001};
        push("pr_gnt", 1, 8'b0000_0010);
        push("pr_vec", 2, 8'b0010_0000);
        @(posedge clk);
        #1;
        req2   = {4'b0000, 4'b1001};
        push("pr_low_gnt", 1, 8'b0000_1000);
        push("pr_low_vec", 2, 8'b0000_1000);
        @(posedge clk);
        #1;
        req2   = 8'b0;

`ifdef C_WMATRIX_ARB_LOCK_EN
        // Packet lock holds port 1 across non-tail updates.
        do_reset();
        weight = {3'd1, 3'd1, 3'd1, 3'd1};
        tail = 1'b1;
        step("lock", 4'b1111, 1'b1, 4'b1000);
        tail = 1'b0;
        repeat (3) step("lock", 4'b1111, 1'b1, 4'b0100);
        tail = 1'b1;
        step("lock", 4'b1111, 1'b1, 4'b0100);
        step("lock_next", 4'b1111, 1'b0, 4'b0010);
`endif

        @(negedge clk);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
